// File: rtl/sha256_round_ctrl_pkg.sv
// Shared SHA-256 definitions: controller state encoding, default sizing and
// the initial hash value used by the datapath when iv_sel is asserted.
package sha256_pkg;

  localparam int ROUNDS_DEFAULT = 64;
  localparam int IDX_W_DEFAULT  = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROUND  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // H0 is the most significant word
  localparam logic [7:0][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Control bundle between the block buffer / message scheduler, the round
// controller and the compression register file.
interface sha256_round_ctrl_if
  import sha256_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready
  // are both 1; valid holds its payload until accepted, ready may toggle freely.
  logic             blk_valid;
  logic             blk_first;
  logic             blk_last;
  logic             blk_ready;
  logic             w_valid;
  logic             w_ack;
  logic             iv_sel;
  logic             init_load;
  logic             reg_start;
  logic [IDX_W-1:0] round_idx;
  logic             hash_update;
  logic             digest_valid;
  logic             digest_ready;
  logic             busy;
  state_t           state;

  modport master (
    input  blk_valid, blk_first, blk_last, w_valid, digest_ready,
    output blk_ready, w_ack, iv_sel, init_load, reg_start, round_idx,
           hash_update, digest_valid, busy, state
  );

  modport slave (
    output blk_valid, blk_first, blk_last, w_valid, digest_ready,
    input  blk_ready, w_ack, iv_sel, init_load, reg_start, round_idx,
           hash_update, digest_valid, busy, state
  );

endinterface

// File: rtl/sha256_round_cnt.sv
// Round index counter: synchronous clear, count enable, terminal-count flag
// at ROUNDS-1. Clear has priority so the count never wraps past the last round.
module sha256_round_cnt #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: accepts a block, loads the working registers,
// steps ROUNDS rounds paced by the schedule word handshake, commits the hash.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int IDX_W  = IDX_W_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  sha256_round_ctrl_if.master bus
);

  state_t           state;
  logic             first_q;
  logic             last_q;
  logic             blk_ready_q;
  logic             init_load_q;
  logic             iv_sel_q;
  logic             hash_update_q;
  logic             digest_valid_q;
  logic             busy_q;
  logic             in_round;
  logic             step;
  logic             cnt_clr;
  logic             cnt_tc;
  logic [IDX_W-1:0] cnt;

  assign in_round = (state == S_ROUND);
  assign step     = in_round && bus.w_valid;
  // Clearing on the final step keeps round_idx at 0 through UPDATE/DONE/IDLE
  assign cnt_clr  = (state == S_LOAD) || (step && cnt_tc);

  sha256_round_cnt #(
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) u_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (cnt_clr),
    .en  (step),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  // Output registers are loaded with the value of the state being entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= S_IDLE;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      blk_ready_q    <= 1'b0;
      init_load_q    <= 1'b0;
      iv_sel_q       <= 1'b0;
      hash_update_q  <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.blk_valid && blk_ready_q) begin
            state       <= S_LOAD;
            first_q     <= bus.blk_first;
            last_q      <= bus.blk_last;
            blk_ready_q <= 1'b0;
            init_load_q <= 1'b1;
            iv_sel_q    <= bus.blk_first;
            busy_q      <= 1'b1;
          end else begin
            blk_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          state       <= S_ROUND;
          init_load_q <= 1'b0;
          iv_sel_q    <= 1'b0;
        end
        S_ROUND: begin
          if (bus.w_valid && cnt_tc) begin
            state         <= S_UPDATE;
            hash_update_q <= 1'b1;
            iv_sel_q      <= first_q;
          end
        end
        S_UPDATE: begin
          hash_update_q <= 1'b0;
          iv_sel_q      <= 1'b0;
          if (last_q) begin
            state          <= S_DONE;
            digest_valid_q <= 1'b1;
          end else begin
            state       <= S_IDLE;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        S_DONE: begin
          if (bus.digest_ready) begin
            state          <= S_IDLE;
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          blk_ready_q    <= 1'b0;
          init_load_q    <= 1'b0;
          iv_sel_q       <= 1'b0;
          hash_update_q  <= 1'b0;
          digest_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.blk_ready    = blk_ready_q;
  assign bus.init_load    = init_load_q;
  assign bus.iv_sel       = iv_sel_q;
  assign bus.hash_update  = hash_update_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.busy         = busy_q;
  assign bus.w_ack        = step;
  assign bus.reg_start    = init_load_q || step;
  assign bus.round_idx    = cnt;
  assign bus.state        = state;

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. Accepts one 512-bit block per handshake and drives the load enables of the 32-bit working registers (A–H, T1/T2) and the hash registers H0–H7. Runs 64 rounds gated by the message-schedule word handshake, commits the intermediate hash, and presents a digest-valid/ready handshake after the last block of a message. Sits between the block buffer/message scheduler and the register file of the compression core.

## Interface
- ROUNDS, 64, number of compression rounds; fixed for SHA-256, exposed for bench shortening.
- IDX_W, 6, width of round index; must satisfy 2^IDX_W ≥ ROUNDS.
- CLK  input  1  rising-edge clock.
- RST  input  1  reset, asynchronous and active-low; all state cleared while RST=0.
- blk_valid  input  1  block buffer holds a complete 512-bit block.
- blk_first  input  1  block is the first of a message; qualified with blk_valid.
- blk_last  input  1  block is the last of a message; qualified with blk_valid.
- blk_ready  output  1  controller accepts a block this cycle.
- w_valid  input  1  message scheduler presents W[round_idx] this cycle.
- w_ack  output  1  W[round_idx] consumed; scheduler advances.
- iv_sel  output  1  working-register load source: 1 = IV constants, 0 = H0–H7.
- init_load  output  1  load A–H from the iv_sel source.
- reg_start  output  1  load enable to all working registers (start pin).
- round_idx  output  IDX_W  current round t, also K-ROM address.
- hash_update  output  1  H_i <= H_i + working_i (H loaded from IV first if iv_sel latched).
- digest_valid  output  1  H0–H7 hold the final digest.
- digest_ready  input  1  consumer accepts digest.
- busy  output  1  state ≠ IDLE.

## Operation
- States: IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE: blk_ready=1. Accept on blk_valid&blk_ready; latch blk_first→first_q, blk_last→last_q; go LOAD.
- LOAD (1 cycle): init_load=1, reg_start=1, iv_sel=first_q; round counter cleared to 0; go ROUND.
- ROUND: w_ack=reg_start=w_valid. Counter increments only on w_valid. On w_valid with round_idx=ROUNDS-1, go UPDATE; counter holds at ROUNDS-1 otherwise wraps never.
- w_valid=0 in ROUND: stall; registers hold (reg_start=0), round_idx unchanged, no timeout.
- UPDATE (1 cycle): hash_update=1, iv_sel=first_q; go DONE if last_q else IDLE.
- DONE: digest_valid=1 held until digest_ready; on digest_valid&digest_ready go IDLE same edge. blk_valid ignored in DONE.
- Outputs not listed for a state are 0; round_idx=0 outside ROUND/LOAD.
- blk_first and blk_last both 1: single-block message, IV used and digest produced.
- Reset mid-operation: state→IDLE, counter, first_q, last_q→0; partial hash is discarded, no digest emitted.

## Timing
- Reset values: blk_ready=0 while RST=0, 1 from first edge-free cycle after deassert (IDLE); all other outputs 0, round_idx=0.
- All outputs registered-state decoded (Moore), except w_ack/reg_start in ROUND which follow w_valid combinationally.
- Accept at edge n (w_valid constantly 1): LOAD cycle n+1, ROUND cycles n+2..n+65, UPDATE n+66, digest_valid from n+67 (last block) or blk_ready from n+67.
- Block throughput: ROUNDS+3 cycles per block with no stalls; each w_valid low cycle adds one.
- blk_ready deasserts the cycle after acceptance; back-to-back acceptance not possible.

## Structure
- Shared package sha256_pkg: state enum type, ROUNDS_DEFAULT=64, IDX_W_DEFAULT=6, IV constant array (used by datapath, referenced here only by iv_sel).
- One sub-module: sha256_round_cnt (clear, enable, terminal-count flag at ROUNDS-1); FSM and output decode in sha256_round_ctrl.

## Test plan
- Reset: RST=0 mid-ROUND at round_idx=30 → next cycle all outputs 0, round_idx=0; after release blk_ready=1.
- Single block, first=last=1, w_valid=1: accept at cycle 0 → init_load&iv_sel at 1, round_idx 0..63 on cycles 2..65, hash_update at 66, digest_valid at 67.
- Two-block message: block 2 with first=0,last=1 → iv_sel=0 during its LOAD, only one digest_valid pulse after block 2; block 1 returns to IDLE at cycle 67.
- w_valid low for 5 cycles at round_idx=10 → round_idx stays 10, reg_start=0, w_ack=0; UPDATE delayed 5 cycles (cycle 71).
- Digest backpressure: digest_ready=0 for 8 cycles → digest_valid held, blk_ready=0 while blk_valid=1; ready=1 → IDLE next cycle.
- ROUNDS=4 parameter build: round_idx 0..3, UPDATE at accept+6, digest at accept+7.
